b_ram_scheduler: RTL and testbench

//  Sequences the partial-sum (B) storage RAM of the SCAN decoder. Accepts node-level write

---
 rtl/b_sched_pkg.sv | 20 ++
 rtl/b_ram_scheduler_if.sv | 42 ++++
 rtl/b_burst_seq.sv | 104 ++++++++++
 rtl/b_ram_scheduler.sv | 95 +++++++++
 tb/tb_b_ram_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/b_sched_pkg.sv
// Shared constants, burst-length helpers and FSM state type for the B RAM scheduler.
package b_sched_pkg;

  localparam int unsigned MAX_LAYER  = 8;
  localparam int unsigned WIDE_LAYER = 6;
  localparam int unsigned LAYER_W    = 5;

  typedef enum logic {IDLE, BURST} burst_state_e;

  // Layers above WIDE_LAYER double their beat count per extra layer.
  function automatic int unsigned beats(logic [LAYER_W-1:0] layer);
    if (32'(layer) <= WIDE_LAYER) return 32'd1;
    return 32'd1 << (32'(layer) - WIDE_LAYER);
  endfunction

  function automatic logic legal(logic [LAYER_W-1:0] layer);
    return (layer != '0) && (32'(layer) <= MAX_LAYER);
  endfunction

endpackage

// File: rtl/b_ram_scheduler_if.sv
// Request/ack handshakes and RAM drive signals of the B RAM scheduler.
interface b_ram_scheduler_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 6
);
  import b_sched_pkg::*;

  logic               wr_req;
  logic [LAYER_W-1:0] wr_layer;
  logic [ADDR_W-1:0]  wr_node;
  logic               wr_ack;
  logic               wr_beat;
  logic               wr_done;
  logic               rd_req;
  logic [LAYER_W-1:0] rd_layer;
  logic [ADDR_W-1:0]  rd_node;
  logic               rd_ack;
  logic               rd_valid;
  logic               rd_last;
  logic               req_err;
  logic               w_en;
  logic               r_en;
  logic [LAYER_W-1:0] layer_w;
  logic [LAYER_W-1:0] layer_r;
  logic [ADDR_W-1:0]  w_address;
  logic [ADDR_W-1:0]  r_address;
  logic [CNT_W-1:0]   cnta;
  logic [CNT_W-1:0]   cntb;

  modport master (
    output wr_req, wr_layer, wr_node, rd_req, rd_layer, rd_node,
    input  wr_ack, wr_beat, wr_done, rd_ack, rd_valid, rd_last, req_err,
    input  w_en, r_en, layer_w, layer_r, w_address, r_address, cnta, cntb
  );

  modport slave (
    input  wr_req, wr_layer, wr_node, rd_req, rd_layer, rd_node,
    output wr_ack, wr_beat, wr_done, rd_ack, rd_valid, rd_last, req_err,
    output w_en, r_en, layer_w, layer_r, w_address, r_address, cnta, cntb
  );

endinterface

// File: rtl/b_burst_seq.sv
// Generic request -> multi-beat burst sequencer; one instance per RAM port.
module b_burst_seq
  import b_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               allow_i,
  input  logic               req_i,
  input  logic [LAYER_W-1:0] layer_i,
  input  logic [ADDR_W-1:0]  node_i,
  output logic               take_o,
  output logic               ack_o,
  output logic               en_o,
  output logic               done_o,
  output logic [LAYER_W-1:0] layer_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [CNT_W-1:0]   cnt_o
);

  burst_state_e       state_q, state_d;
  logic               ack_q, ack_d;
  logic               pend_q, pend_d;
  logic               done_q, done_d;
  logic [LAYER_W-1:0] lat_layer_q, lat_layer_d;
  logic [ADDR_W-1:0]  lat_node_q, lat_node_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               take;

  always_comb begin
    state_d     = IDLE;
    done_d      = 1'b0;
    layer_d     = '0;
    addr_d      = '0;
    cnt_d       = '0;
    ack_d       = 1'b0;
    pend_d      = 1'b0;
    lat_layer_d = lat_layer_q;
    lat_node_d  = lat_node_q;
    take        = 1'b0;

    if (pend_q) begin
      state_d = BURST;
      layer_d = lat_layer_q;
      addr_d  = lat_node_q;
      done_d  = (beats(lat_layer_q) == 32'd1);
    end else if (state_q == BURST && !done_q) begin
      state_d = BURST;
      layer_d = layer_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q + CNT_W'(1);
      done_d  = (32'(cnt_q) + 32'd2 == beats(layer_q));
    end

    // A new request may be acked while the final beat goes out, so bursts chain without a gap.
    // ack_q high means the requester is still presenting the request just accepted.
    take = req_i && !ack_q && allow_i && (state_d == IDLE || done_d);
    if (take) begin
      ack_d = 1'b1;
      if (legal(layer_i)) begin
        pend_d      = 1'b1;
        lat_layer_d = layer_i;
        lat_node_d  = node_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      lat_layer_q <= '0;
      lat_node_q  <= '0;
      layer_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      lat_layer_q <= lat_layer_d;
      lat_node_q  <= lat_node_d;
      layer_q     <= layer_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign take_o  = take;
  assign ack_o   = ack_q;
  assign en_o    = (state_q == BURST);
  assign done_o  = done_q;
  assign layer_o = layer_q;
  assign addr_o  = addr_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/b_ram_scheduler.sv
// B RAM scheduler: write and read burst sequencers with a read-after-write hazard guard.
module b_ram_scheduler
  import b_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 6
) (
  input logic               clk,
  input logic               rst_n,
  b_ram_scheduler_if.slave  bus
);

  logic               wr_take, rd_take, rd_allow, rd_done;
  logic               wr_new, hz_retire, hit_new, hit_held;
  logic               hz_q, pend_q;
  logic [LAYER_W-1:0] hz_layer_q;
  logic [ADDR_W-1:0]  hz_node_q;
  logic               req_err_q, rd_valid_q, rd_last_q;

  assign wr_new    = wr_take && legal(bus.wr_layer);
  // The held write stops blocking on its last beat unless a newer write was acked meanwhile.
  assign hz_retire = bus.wr_done && !pend_q;
  assign hit_new   = wr_new && (bus.rd_layer == bus.wr_layer) && (bus.rd_node == bus.wr_node);
  assign hit_held  = hz_q && !hz_retire && (bus.rd_layer == hz_layer_q) &&
                     (bus.rd_node == hz_node_q);
  assign rd_allow  = !(hit_new || hit_held);

  b_burst_seq #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_wr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .allow_i (1'b1),
    .req_i   (bus.wr_req),
    .layer_i (bus.wr_layer),
    .node_i  (bus.wr_node),
    .take_o  (wr_take),
    .ack_o   (bus.wr_ack),
    .en_o    (bus.w_en),
    .done_o  (bus.wr_done),
    .layer_o (bus.layer_w),
    .addr_o  (bus.w_address),
    .cnt_o   (bus.cnta)
  );

  b_burst_seq #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_rd_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .allow_i (rd_allow),
    .req_i   (bus.rd_req),
    .layer_i (bus.rd_layer),
    .node_i  (bus.rd_node),
    .take_o  (rd_take),
    .ack_o   (bus.rd_ack),
    .en_o    (bus.r_en),
    .done_o  (rd_done),
    .layer_o (bus.layer_r),
    .addr_o  (bus.r_address),
    .cnt_o   (bus.cntb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_q       <= 1'b0;
      hz_layer_q <= '0;
      hz_node_q  <= '0;
      pend_q     <= 1'b0;
      req_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      if (wr_new) begin
        hz_q       <= 1'b1;
        hz_layer_q <= bus.wr_layer;
        hz_node_q  <= bus.wr_node;
      end else if (hz_retire) begin
        hz_q <= 1'b0;
      end
      pend_q     <= wr_new;
      req_err_q  <= (wr_take && !legal(bus.wr_layer)) || (rd_take && !legal(bus.rd_layer));
      rd_valid_q <= bus.r_en;
      rd_last_q  <= bus.r_en && rd_done;
    end
  end

  assign bus.wr_beat  = bus.w_en;
  assign bus.req_err  = req_err_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;

endmodule

// File: tb/tb_b_ram_scheduler.sv
// Scoreboard bench for b_ram_scheduler: directed requests, cycle-stamped expected events.
module tb_b_ram_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {int cyc; int layer; int addr; int cnt; bit flag;} ev_t;
  typedef struct {int layer; int node;} stim_t;

  ev_t   q_wack[$], q_rack[$], q_wb[$], q_rb[$], q_rv[$];
  stim_t wr_stim[$], rd_stim[$];

  b_ram_scheduler_if #(.ADDR_W(9), .CNT_W(6)) bus ();

  b_ram_scheduler #(.ADDR_W(9), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input int l, input int a, input int n, input bit f);
    ev_t e;
    e.cyc = c; e.layer = l; e.addr = a; e.cnt = n; e.flag = f;
    return e;
  endfunction

  function automatic stim_t st(input int l, input int n);
    stim_t s;
    s.layer = l; s.node = n;
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_ack"}, bus.wr_ack, 0);
    chk({tag, "_rd_ack"}, bus.rd_ack, 0);
    chk({tag, "_beat_done"}, int'({bus.wr_beat, bus.wr_done}), 0);
    chk({tag, "_rd_valid_last"}, int'({bus.rd_valid, bus.rd_last}), 0);
    chk({tag, "_req_err"}, bus.req_err, 0);
    chk({tag, "_w_en"}, bus.w_en, 0);
    chk({tag, "_r_en"}, bus.r_en, 0);
    chk({tag, "_w_side"}, int'({bus.layer_w, bus.w_address, bus.cnta}), 0);
    chk({tag, "_r_side"}, int'({bus.layer_r, bus.r_address, bus.cntb}), 0);
  endtask

  // Drivers hold each request until its ack is seen, then present the next queued one.
  initial begin : wr_drv
    stim_t s;
    int n;
    bus.wr_req = 1'b0; bus.wr_layer = '0; bus.wr_node = '0;
    forever begin
      @(posedge clk); #2;
      if (wr_stim.size() > 0) begin
        s = wr_stim.pop_front();
        bus.wr_req = 1'b1; bus.wr_layer = 5'(s.layer); bus.wr_node = 9'(s.node);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wr_ack && n < 50);
        if (!bus.wr_ack) chk("wr_ack_timeout", bus.wr_ack, 1);
      end else begin
        bus.wr_req = 1'b0;
      end
    end
  end

  initial begin : rd_drv
    stim_t s;
    int n;
    bus.rd_req = 1'b0; bus.rd_layer = '0; bus.rd_node = '0;
    forever begin
      @(posedge clk); #2;
      if (rd_stim.size() > 0) begin
        s = rd_stim.pop_front();
        bus.rd_req = 1'b1; bus.rd_layer = 5'(s.layer); bus.rd_node = 9'(s.node);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rd_ack && n < 50);
        if (!bus.rd_ack) chk("rd_ack_timeout", bus.rd_ack, 1);
      end else begin
        bus.rd_req = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    bit  exp_err;
    if (rst_n) begin
      exp_err = 1'b0;
      if (bus.wr_ack) begin
        if (q_wack.size() == 0) chk("wr_ack_unexpected", bus.wr_ack, 0);
        else begin
          e = q_wack.pop_front();
          chk("wr_ack_cycle", cyc, e.cyc);
          exp_err |= e.flag;
        end
      end
      if (bus.rd_ack) begin
        if (q_rack.size() == 0) chk("rd_ack_unexpected", bus.rd_ack, 0);
        else begin
          e = q_rack.pop_front();
          chk("rd_ack_cycle", cyc, e.cyc);
          exp_err |= e.flag;
        end
      end
      if (bus.wr_ack || bus.rd_ack) chk("req_err", bus.req_err, int'(exp_err));
      else if (bus.req_err) chk("req_err_unexpected", bus.req_err, 0);

      if (bus.w_en) begin
        if (q_wb.size() == 0) chk("w_en_unexpected", bus.w_en, 0);
        else begin
          e = q_wb.pop_front();
          chk("w_cycle", cyc, e.cyc);
          chk("layer_w", bus.layer_w, e.layer);
          chk("w_address", bus.w_address, e.addr);
          chk("cnta", bus.cnta, e.cnt);
          chk("wr_done", bus.wr_done, int'(e.flag));
          chk("wr_beat", bus.wr_beat, 1);
        end
      end else begin
        chk("w_idle", int'({bus.wr_beat, bus.wr_done, bus.layer_w, bus.w_address, bus.cnta}), 0);
      end

      if (bus.r_en) begin
        if (q_rb.size() == 0) chk("r_en_unexpected", bus.r_en, 0);
        else begin
          e = q_rb.pop_front();
          chk("r_cycle", cyc, e.cyc);
          chk("layer_r", bus.layer_r, e.layer);
          chk("r_address", bus.r_address, e.addr);
          chk("cntb", bus.cntb, e.cnt);
        end
      end else begin
        chk("r_idle", int'({bus.layer_r, bus.r_address, bus.cntb}), 0);
      end

      if (bus.rd_valid) begin
        if (q_rv.size() == 0) chk("rd_valid_unexpected", bus.rd_valid, 0);
        else begin
          e = q_rv.pop_front();
          chk("rd_valid_cycle", cyc, e.cyc);
          chk("rd_last", bus.rd_last, int'(e.flag));
        end
      end else if (bus.rd_last) begin
        chk("rd_last_without_valid", bus.rd_last, 0);
      end
    end
  end

  initial begin : main
    int b;
    #3;
    check_all_zero("reset");
    #19 rst_n = 1'b1;

    // L3 write node 5: one beat, done with it.
    @(posedge clk); #1; b = cyc;
    wr_stim.push_back(st(3, 5));
    q_wack.push_back(mk(b + 1, 0, 0, 0, 1'b0));
    q_wb.push_back(mk(b + 2, 3, 5, 0, 1'b1));
    repeat (8) @(posedge clk);

    // Two chained L8 writes: the second ack lands on the first burst's done beat.
    @(posedge clk); #1; b = cyc;
    wr_stim.push_back(st(8, 1));
    wr_stim.push_back(st(8, 7));
    q_wack.push_back(mk(b + 1, 0, 0, 0, 1'b0));
    q_wack.push_back(mk(b + 5, 0, 0, 0, 1'b0));
    for (int k = 0; k < 4; k++) q_wb.push_back(mk(b + 2 + k, 8, 1, k, k == 3));
    for (int k = 0; k < 4; k++) q_wb.push_back(mk(b + 6 + k, 8, 7, k, k == 3));
    repeat (14) @(posedge clk);

    // L7 write and matching L7 read together: read acked the cycle after wr_done.
    @(posedge clk); #1; b = cyc;
    wr_stim.push_back(st(7, 2));
    rd_stim.push_back(st(7, 2));
    q_wack.push_back(mk(b + 1, 0, 0, 0, 1'b0));
    q_wb.push_back(mk(b + 2, 7, 2, 0, 1'b0));
    q_wb.push_back(mk(b + 3, 7, 2, 1, 1'b1));
    q_rack.push_back(mk(b + 4, 0, 0, 0, 1'b0));
    q_rb.push_back(mk(b + 5, 7, 2, 0, 1'b0));
    q_rb.push_back(mk(b + 6, 7, 2, 1, 1'b0));
    q_rv.push_back(mk(b + 6, 0, 0, 0, 1'b0));
    q_rv.push_back(mk(b + 7, 0, 0, 0, 1'b1));
    repeat (12) @(posedge clk);

    // Non-matching L5 write and L6 read run side by side.
    @(posedge clk); #1; b = cyc;
    wr_stim.push_back(st(5, 3));
    rd_stim.push_back(st(6, 0));
    q_wack.push_back(mk(b + 1, 0, 0, 0, 1'b0));
    q_rack.push_back(mk(b + 1, 0, 0, 0, 1'b0));
    q_wb.push_back(mk(b + 2, 5, 3, 0, 1'b1));
    q_rb.push_back(mk(b + 2, 6, 0, 0, 1'b0));
    q_rv.push_back(mk(b + 3, 0, 0, 0, 1'b1));
    repeat (8) @(posedge clk);

    // L8 read node 9: four read beats, rd_last on the fourth delayed beat.
    @(posedge clk); #1; b = cyc;
    rd_stim.push_back(st(8, 9));
    q_rack.push_back(mk(b + 1, 0, 0, 0, 1'b0));
    for (int k = 0; k < 4; k++) q_rb.push_back(mk(b + 2 + k, 8, 9, k, 1'b0));
    for (int k = 0; k < 4; k++) q_rv.push_back(mk(b + 3 + k, 0, 0, 0, k == 3));
    repeat (10) @(posedge clk);

    // Illegal layers on both ports: acked with req_err, never enabled.
    @(posedge clk); #1; b = cyc;
    wr_stim.push_back(st(9, 4));
    rd_stim.push_back(st(0, 4));
    q_wack.push_back(mk(b + 1, 0, 0, 0, 1'b1));
    q_rack.push_back(mk(b + 1, 0, 0, 0, 1'b1));
    repeat (8) @(posedge clk);

    // Reset during an L8 write once cnta has reached 2.
    @(posedge clk); #1; b = cyc;
    wr_stim.push_back(st(8, 1));
    q_wack.push_back(mk(b + 1, 0, 0, 0, 1'b0));
    for (int k = 0; k < 3; k++) q_wb.push_back(mk(b + 2 + k, 8, 1, k, 1'b0));
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 check_all_zero("mid_burst_reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 check_all_zero("after_reset");

    chk("wr_ack_left", q_wack.size(), 0);
    chk("rd_ack_left", q_rack.size(), 0);
    chk("w_beats_left", q_wb.size(), 0);
    chk("r_beats_left", q_rb.size(), 0);
    chk("rd_valid_left", q_rv.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
